// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program-counter generator with redirects and return-address stack
//
// Purpose: holds the fetch PC and offers it to instruction fetch through a
// valid/ready handshake. Applies trap/jalr/jal/branch redirects from execute,
// flags misaligned control-flow targets, and keeps a circular return-address
// stack for call/return prediction.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   fetch_valid_o/fetch_ready_i fetch request handshake
//   pc_o                        current fetch PC
//   ex_pc_i, rs1_i, imm_i       execute-stage operands for target computation
//   branch_en_i, jal_en_i,
//   jalr_en_i, trap_en_i        redirect requests (trap highest priority)
//   trap_vec_i                  trap target
//   halt_i                      stop fetching
//   link_o                      ex_pc_i + 4, combinational
//   ras_push_i, ras_pop_i       return-address stack controls
//   ras_top_o, ras_valid_o      stack prediction and non-empty flag
//   misalign_o, bad_addr_o      misaligned-target pulse and captured address
module pc_gen #(
  parameter int unsigned XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned IALIGN    = 4,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            branch_en_i,
  input  logic            jal_en_i,
  input  logic            jalr_en_i,
  input  logic            trap_en_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            halt_i,
  output logic [XLEN-1:0] link_o,
  input  logic            ras_push_i,
  input  logic            ras_pop_i,
  output logic [XLEN-1:0] ras_top_o,
  output logic            ras_valid_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] bad_addr_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
  localparam logic [PW:0]     RAS_FULL   = (PW+1)'(RAS_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;

  logic [XLEN-1:0] target;
  logic            redirect;
  logic            check_align;
  logic            misaligned;

  // Return-address stack: ptr_q is the next slot to write, so the top lives
  // at ptr_q-1. The pointer wraps naturally, which overwrites the oldest entry
  // once the stack is full.
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr_q;
  logic [PW:0]     ras_cnt_q;
  logic [PW-1:0]   ras_top_idx;

  assign link_o        = ex_pc_i + XLEN'(4);
  assign fetch_valid_o = (state_q == ST_RUN);
  assign pc_o          = pc_q;
  assign misalign_o    = misalign_q;
  assign bad_addr_o    = bad_addr_q;

  assign ras_top_idx = ras_ptr_q - PW'(1);
  assign ras_valid_o = (ras_cnt_q != '0);
  assign ras_top_o   = ras_valid_o ? ras_q[ras_top_idx] : '0;

  // Target selection, priority trap > jalr > jal > branch.
  always_comb begin
    target      = '0;
    redirect    = 1'b0;
    check_align = 1'b0;
    if (trap_en_i) begin
      target   = trap_vec_i;
      redirect = 1'b1;
    end else if (jalr_en_i) begin
      target      = (rs1_i + imm_i) & ~XLEN'(1);
      redirect    = 1'b1;
      check_align = 1'b1;
    end else if (jal_en_i || branch_en_i) begin
      target      = ex_pc_i + imm_i;
      redirect    = 1'b1;
      check_align = 1'b1;
    end
    misaligned = check_align && ((target & ALIGN_MASK) != '0);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    bad_addr_d = bad_addr_q;

    // A misaligned target leaves pc_o alone; the trap controller follows up.
    if (redirect) begin
      if (misaligned) begin
        misalign_d = 1'b1;
        bad_addr_d = target;
      end else begin
        pc_d = target;
      end
    end else if (state_q == ST_RUN && fetch_ready_i) begin
      pc_d = pc_q + XLEN'(IALIGN);
    end

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (!redirect && halt_i) state_d = ST_HALT;
      ST_HALT: if (redirect) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  // Push+pop together on a non-empty stack rewrites the top in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (ras_push_i && (!ras_pop_i || !ras_valid_o)) begin
      ras_ptr_q <= ras_ptr_q + PW'(1);
      if (ras_cnt_q != RAS_FULL) ras_cnt_q <= ras_cnt_q + (PW+1)'(1);
    end else if (ras_pop_i && !ras_push_i && ras_valid_o) begin
      ras_ptr_q <= ras_top_idx;
      ras_cnt_q <= ras_cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && ras_push_i) begin
      if (ras_pop_i && ras_valid_o) ras_q[ras_top_idx] <= link_o;
      else                          ras_q[ras_ptr_q]   <= link_o;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic [31:0] ex_pc, rs1, imm, trap_vec;
  logic        br_en, jal_en, jalr_en, trap_en, halt;
  logic        push, pop;

  logic        valid4, valid2;
  logic [31:0] pc4, pc2, link4, link2, top4, top2, bad4, bad2;
  logic        rasv4, rasv2, mis4, mis2;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .IALIGN(4), .RAS_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .fetch_valid_o(valid4), .fetch_ready_i(ready),
    .pc_o(pc4), .ex_pc_i(ex_pc), .rs1_i(rs1), .imm_i(imm),
    .branch_en_i(br_en), .jal_en_i(jal_en), .jalr_en_i(jalr_en),
    .trap_en_i(trap_en), .trap_vec_i(trap_vec), .halt_i(halt),
    .link_o(link4), .ras_push_i(push), .ras_pop_i(pop),
    .ras_top_o(top4), .ras_valid_o(rasv4), .misalign_o(mis4), .bad_addr_o(bad4)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .IALIGN(2), .RAS_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .fetch_valid_o(valid2), .fetch_ready_i(ready),
    .pc_o(pc2), .ex_pc_i(ex_pc), .rs1_i(rs1), .imm_i(imm),
    .branch_en_i(br_en), .jal_en_i(jal_en), .jalr_en_i(jalr_en),
    .trap_en_i(trap_en), .trap_vec_i(trap_vec), .halt_i(halt),
    .link_o(link2), .ras_push_i(push), .ras_pop_i(pop),
    .ras_top_o(top2), .ras_valid_o(rasv2), .misalign_o(mis2), .bad_addr_o(bad2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ex_pc = '0; rs1 = '0; imm = '0; trap_vec = '0;
    br_en = 0; jal_en = 0; jalr_en = 0; trap_en = 0; halt = 0;
    push = 0; pop = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8; exp_seq[3] = 32'hC;
    clear_in();
    rst_n = 0; ready = 1;
    tick(); tick();
    vec_cnt++; if (valid4 !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %b exp 0", valid4); end
    vec_cnt++; if (pc4 !== 32'h0) begin err_cnt++; $display("FAIL reset_pc got %h exp 0", pc4); end
    vec_cnt++; if (mis4 !== 1'b0 || bad4 !== 32'h0) begin err_cnt++; $display("FAIL reset_misalign got %b/%h exp 0/0", mis4, bad4); end
    vec_cnt++; if (rasv4 !== 1'b0 || top4 !== 32'h0) begin err_cnt++; $display("FAIL reset_ras got %b/%h exp 0/0", rasv4, top4); end
    rst_n = 1;
    tick();
    vec_cnt++; if (valid4 !== 1'b1) begin err_cnt++; $display("FAIL boot_to_run got %b exp 1", valid4); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (pc4 !== exp_seq[i]) begin err_cnt++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc4, exp_seq[i]); end
      tick();
    end
  endtask

  task automatic test_stall();
    clear_in();
    ready = 1; jal_en = 1; ex_pc = 32'h100; imm = 32'h0;
    tick();
    clear_in(); ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++; if (pc4 !== 32'h100 || valid4 !== 1'b1) begin err_cnt++; $display("FAIL stall_hold[%0d] got %h/%b exp 00000100/1", i, pc4, valid4); end
    end
    ready = 1;
    tick();
    vec_cnt++; if (pc4 !== 32'h104) begin err_cnt++; $display("FAIL stall_release got %h exp 00000104", pc4); end
  endtask

  task automatic test_priority();
    clear_in(); ready = 1;
    trap_en = 1; trap_vec = 32'h80; jal_en = 1; ex_pc = 32'h40; imm = 32'h20;
    tick();
    vec_cnt++; if (pc4 !== 32'h80) begin err_cnt++; $display("FAIL trap_over_jal got %h exp 00000080", pc4); end
    vec_cnt++; if (pc2 !== 32'h80) begin err_cnt++; $display("FAIL trap_over_jal_i2 got %h exp 00000080", pc2); end
    clear_in();
    jalr_en = 1; rs1 = 32'h300; imm = 32'h10; jal_en = 1; ex_pc = 32'h40; br_en = 1;
    tick();
    vec_cnt++; if (pc4 !== 32'h310) begin err_cnt++; $display("FAIL jalr_over_jal got %h exp 00000310", pc4); end
  endtask

  task automatic test_jalr_align();
    clear_in(); ready = 0;
    jalr_en = 1; rs1 = 32'h203; imm = 32'h0;
    tick();
    vec_cnt++; if (pc2 !== 32'h202) begin err_cnt++; $display("FAIL jalr_ialign2_pc got %h exp 00000202", pc2); end
    vec_cnt++; if (mis2 !== 1'b0) begin err_cnt++; $display("FAIL jalr_ialign2_mis got %b exp 0", mis2); end
    vec_cnt++; if (mis4 !== 1'b1) begin err_cnt++; $display("FAIL jalr_ialign4_mis got %b exp 1", mis4); end
    vec_cnt++; if (bad4 !== 32'h202) begin err_cnt++; $display("FAIL jalr_ialign4_bad got %h exp 00000202", bad4); end
    vec_cnt++; if (pc4 !== 32'h310 || valid4 !== 1'b1) begin err_cnt++; $display("FAIL jalr_ialign4_pc got %h/%b exp 00000310/1", pc4, valid4); end
    clear_in();
    tick();
    vec_cnt++; if (mis4 !== 1'b0 || bad4 !== 32'h202) begin err_cnt++; $display("FAIL misalign_pulse got %b/%h exp 0/00000202", mis4, bad4); end
    jal_en = 1; ex_pc = 32'h20; imm = 32'h6;
    tick();
    vec_cnt++; if (mis4 !== 1'b1 || bad4 !== 32'h26 || pc4 !== 32'h310) begin err_cnt++; $display("FAIL jal_misalign got %b/%h/%h exp 1/00000026/00000310", mis4, bad4, pc4); end
  endtask

  task automatic test_halt();
    clear_in(); ready = 0;
    jal_en = 1; ex_pc = 32'h10; imm = 32'h0;
    tick();
    clear_in(); halt = 1;
    tick();
    vec_cnt++; if (valid4 !== 1'b0 || pc4 !== 32'h10) begin err_cnt++; $display("FAIL halt_enter got %b/%h exp 0/00000010", valid4, pc4); end
    halt = 0; ready = 1;
    tick();
    vec_cnt++; if (valid4 !== 1'b0 || pc4 !== 32'h10) begin err_cnt++; $display("FAIL halt_stay got %b/%h exp 0/00000010", valid4, pc4); end
    br_en = 1; ex_pc = 32'h10; imm = 32'hFFFF_FFF8;
    tick();
    vec_cnt++; if (valid4 !== 1'b1 || pc4 !== 32'h08) begin err_cnt++; $display("FAIL halt_branch_exit got %b/%h exp 1/00000008", valid4, pc4); end
  endtask

  task automatic test_wrap();
    clear_in(); ready = 1;
    jal_en = 1; ex_pc = 32'hFFFF_FFFC; imm = 32'h0;
    #1;
    vec_cnt++; if (link4 !== 32'h0) begin err_cnt++; $display("FAIL link_wrap got %h exp 00000000", link4); end
    tick();
    clear_in();
    vec_cnt++; if (pc4 !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL wrap_setup got %h exp fffffffc", pc4); end
    tick();
    vec_cnt++; if (pc4 !== 32'h0) begin err_cnt++; $display("FAIL pc_wrap got %h exp 00000000", pc4); end
    jal_en = 1; ex_pc = 32'hFFFF_FFF0; imm = 32'h14;
    tick();
    vec_cnt++; if (pc4 !== 32'h4) begin err_cnt++; $display("FAIL target_wrap got %h exp 00000004", pc4); end
  endtask

  task automatic test_ras();
    logic [31:0] exp_pop [4];
    exp_pop[0] = 32'h54; exp_pop[1] = 32'h44; exp_pop[2] = 32'h34; exp_pop[3] = 32'h24;
    clear_in();
    for (int i = 1; i <= 5; i++) begin
      ex_pc = 32'(i * 16); push = 1;
      tick();
      vec_cnt++; if (rasv4 !== 1'b1 || top4 !== 32'(i * 16 + 4)) begin err_cnt++; $display("FAIL ras_push[%0d] got %b/%h exp 1/%h", i, rasv4, top4, 32'(i * 16 + 4)); end
    end
    push = 0;
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (rasv4 !== 1'b1 || top4 !== exp_pop[i]) begin err_cnt++; $display("FAIL ras_pop[%0d] got %b/%h exp 1/%h", i, rasv4, top4, exp_pop[i]); end
      pop = 1;
      tick();
    end
    vec_cnt++; if (rasv4 !== 1'b0 || top4 !== 32'h0) begin err_cnt++; $display("FAIL ras_empty got %b/%h exp 0/0", rasv4, top4); end
    tick();
    vec_cnt++; if (rasv4 !== 1'b0 || top4 !== 32'h0) begin err_cnt++; $display("FAIL ras_underflow got %b/%h exp 0/0", rasv4, top4); end
    push = 1; pop = 1; ex_pc = 32'h60;
    tick();
    vec_cnt++; if (rasv4 !== 1'b1 || top4 !== 32'h64) begin err_cnt++; $display("FAIL ras_pushpop_empty got %b/%h exp 1/00000064", rasv4, top4); end
    ex_pc = 32'h70;
    tick();
    vec_cnt++; if (rasv4 !== 1'b1 || top4 !== 32'h74) begin err_cnt++; $display("FAIL ras_pushpop_replace got %b/%h exp 1/00000074", rasv4, top4); end
    push = 0;
    tick();
    vec_cnt++; if (rasv4 !== 1'b0) begin err_cnt++; $display("FAIL ras_pushpop_count got %b exp 0", rasv4); end
    pop = 0;
  endtask

  task automatic test_reset_midrun();
    clear_in(); ready = 1;
    push = 1; ex_pc = 32'h10; jal_en = 1; imm = 32'h30;
    tick();
    vec_cnt++; if (rasv4 !== 1'b1 || pc4 !== 32'h40) begin err_cnt++; $display("FAIL midrun_setup got %b/%h exp 1/00000040", rasv4, pc4); end
    clear_in(); rst_n = 0;
    tick();
    vec_cnt++; if (rasv4 !== 1'b0 || pc4 !== 32'h0 || valid4 !== 1'b0) begin err_cnt++; $display("FAIL midrun_reset got %b/%h/%b exp 0/0/0", rasv4, pc4, valid4); end
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_priority();
    test_jalr_align();
    test_halt();
    test_wrap();
    test_ras();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
